// File: rtl/pbs_battle_core.sv
// Battle-resolution datapath: HP registers, LFSR-driven AI move / accuracy roll, 3-stage damage pipeline.
// Optional build macro PBS_FAINT_LOCK_EN blocks new calculations once either combatant reaches 0 HP.
module pbs_battle_core #(
    parameter logic [3:0]  HP_INIT   = 4'd9,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       actr,
    input  logic [1:0] p_move,
    input  logic       target,
    input  logic       calc_dmg,
    input  logic       app_dmg,
    output logic [3:0] p_hp,
    output logic [3:0] ai_hp,
    output logic       busy,
    output logic       result_valid,
    output logic       hit,
    output logic [2:0] dmg_out,
    output logic [1:0] move_used
);

    localparam int DATA_W = 4;
    localparam int COEF_W = 3;

    function automatic logic [COEF_W-1:0] move_dmg(input logic [1:0] move);
        case (move)
            2'd0:    move_dmg = 3'd1;
            2'd1:    move_dmg = 3'd2;
            2'd2:    move_dmg = 3'd3;
            default: move_dmg = 3'd4;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] move_acc(input logic [1:0] move);
        case (move)
            2'd0:    move_acc = 4'd15;
            2'd1:    move_acc = 4'd12;
            2'd2:    move_acc = 4'd8;
            default: move_acc = 4'd4;
        endcase
    endfunction

    // HP never wraps: a hit that would go negative clamps to zero.
    function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] hp,
                                                  input logic [COEF_W-1:0] dmg,
                                                  input logic              is_hit);
        logic signed [DATA_W+1:0] diff;
        diff = $signed({2'b00, hp}) - $signed({{(DATA_W+2-COEF_W){1'b0}}, dmg});
        if (!is_hit)
            sat_sub = hp;
        else if (diff[DATA_W+1] || diff == '0)
            sat_sub = '0;
        else
            sat_sub = diff[DATA_W-1:0];
    endfunction

    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic        lock;
    logic        accept;
    logic        commit;

    logic [1:0]        move_p0;
    logic              tgt_p0;
    logic [DATA_W-1:0] roll_p0;
    logic              vld_p0;

    logic [1:0]        move_p1;
    logic              tgt_p1;
    logic [COEF_W-1:0] dmg_p1;
    logic              hit_p1;
    logic [DATA_W-1:0] hp_p1;
    logic              vld_p1;

    logic              tgt_p2;
    logic [DATA_W-1:0] hp_new_p2;

    assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

`ifdef PBS_FAINT_LOCK_EN
    assign lock = (p_hp == '0) || (ai_hp == '0);
`else
    assign lock = 1'b0;
`endif

    assign accept = calc_dmg && !busy && !lock;
    assign commit = app_dmg && result_valid;

    always_ff @(posedge clk) begin
        // stage 1: capture move, victim and roll from the pre-edge LFSR
        if (accept) begin
            move_p0 <= actr ? lfsr[1:0] : p_move;
            tgt_p0  <= target;
            roll_p0 <= lfsr[5:2];
        end
        // stage 2: table lookup, hit decision, HP snapshot
        if (vld_p0) begin
            move_p1 <= move_p0;
            tgt_p1  <= tgt_p0;
            dmg_p1  <= move_dmg(move_p0);
            hit_p1  <= move_acc(move_p0) >= roll_p0;
            hp_p1   <= tgt_p0 ? ai_hp : p_hp;
        end
        // stage 3: saturating new HP, held until commit
        if (vld_p1) begin
            tgt_p2    <= tgt_p1;
            hp_new_p2 <= sat_sub(hp_p1, dmg_p1, hit_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr         <= LFSR_SEED;
            busy         <= 1'b0;
            vld_p0       <= 1'b0;
            vld_p1       <= 1'b0;
            result_valid <= 1'b0;
            hit          <= 1'b0;
            dmg_out      <= '0;
            move_used    <= '0;
            p_hp         <= HP_INIT;
            ai_hp        <= HP_INIT;
        end else begin
            lfsr   <= {lfsr[14:0], lfsr_fb};
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            if (accept)
                busy <= 1'b1;
            if (vld_p1) begin
                result_valid <= 1'b1;
                hit          <= hit_p1;
                dmg_out      <= hit_p1 ? dmg_p1 : '0;
                move_used    <= move_p1;
            end
            if (commit) begin
                result_valid <= 1'b0;
                busy         <= 1'b0;
                if (tgt_p2)
                    ai_hp <= hp_new_p2;
                else
                    p_hp <= hp_new_p2;
            end
        end
    end

endmodule

// File: tb/tb_pbs_battle_core.sv
// Self-checking bench for pbs_battle_core: transaction-level reference model plus directed literal checks.
module tb_pbs_battle_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       actr;
    logic [1:0] p_move;
    logic       target;
    logic       calc_dmg;
    logic       app_dmg;
    logic [3:0] p_hp;
    logic [3:0] ai_hp;
    logic       busy;
    logic       result_valid;
    logic       hit;
    logic [2:0] dmg_out;
    logic [1:0] move_used;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pbs_battle_core dut (
        .clk(clk), .rst(rst), .actr(actr), .p_move(p_move), .target(target),
        .calc_dmg(calc_dmg), .app_dmg(app_dmg), .p_hp(p_hp), .ai_hp(ai_hp),
        .busy(busy), .result_valid(result_valid), .hit(hit), .dmg_out(dmg_out),
        .move_used(move_used)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic        m_ready = 1'b0;
    logic [15:0] m_lfsr;
    logic [3:0]  m_php, m_aihp;
    logic        m_busy;
    int          m_age;
    logic        m_hit, m_tgt;
    logic [1:0]  m_move;
    logic [2:0]  m_dmg;
    logic [3:0]  m_new;
    logic        o_hit;
    logic [2:0]  o_dmg;
    logic [1:0]  o_move;

    logic [1:0]  c_mv;
    logic [3:0]  c_roll, c_acc, c_cur, c_new;
    logic [2:0]  c_dm;
    logic        c_hit, c_rv, c_lock, c_acc_ok, c_com;
    logic [15:0] c_lfsr_nx;

    always_comb begin
        c_mv   = actr ? m_lfsr[1:0] : p_move;
        c_roll = m_lfsr[5:2];
        c_dm   = {1'b0, c_mv} + 3'd1;
        case (c_mv)
            2'd0: c_acc = 4'd15;
            2'd1: c_acc = 4'd12;
            2'd2: c_acc = 4'd8;
            default: c_acc = 4'd4;
        endcase
        c_hit = c_acc >= c_roll;
        c_cur = target ? m_aihp : m_php;
        if (!c_hit)
            c_new = c_cur;
        else if (c_cur > {1'b0, c_dm})
            c_new = c_cur - {1'b0, c_dm};
        else
            c_new = 4'd0;
        c_rv = m_busy && (m_age >= 2);
`ifdef PBS_FAINT_LOCK_EN
        c_lock = (m_php == 4'd0) || (m_aihp == 4'd0);
`else
        c_lock = 1'b0;
`endif
        c_acc_ok  = calc_dmg && !m_busy && !c_lock;
        c_com     = app_dmg && c_rv;
        c_lfsr_nx = {m_lfsr[14:0], ^(m_lfsr & 16'hB400)};
    end

    always @(posedge clk) begin
        if (rst === 1'b0) begin
            m_ready <= 1'b1;
            m_lfsr  <= 16'hACE1;
            m_php   <= 4'd9;
            m_aihp  <= 4'd9;
            m_busy  <= 1'b0;
            m_age   <= 0;
            o_hit   <= 1'b0;
            o_dmg   <= 3'd0;
            o_move  <= 2'd0;
        end else if (m_ready) begin
            m_lfsr <= c_lfsr_nx;
            if (c_acc_ok) begin
                m_busy <= 1'b1;
                m_age  <= 0;
                m_hit  <= c_hit;
                m_dmg  <= c_hit ? c_dm : 3'd0;
                m_move <= c_mv;
                m_tgt  <= target;
                m_new  <= c_new;
            end else if (m_busy && m_age < 2) begin
                m_age <= m_age + 1;
            end
            if (m_busy && m_age == 1) begin
                o_hit  <= m_hit;
                o_dmg  <= m_dmg;
                o_move <= m_move;
            end
            if (c_com) begin
                m_busy <= 1'b0;
                if (m_tgt) m_aihp <= m_new;
                else       m_php  <= m_new;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            check("p_hp",         p_hp,         m_php);
            check("ai_hp",        ai_hp,        m_aihp);
            check("busy",         busy,         m_busy);
            check("result_valid", result_valid, c_rv);
            check("hit",          hit,          o_hit);
            check("dmg_out",      dmg_out,      o_dmg);
            check("move_used",    move_used,    o_move);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_reset();
        rst      = 1'b0;
        calc_dmg = 1'b0;
        app_dmg  = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic start_calc(input logic a, input logic [1:0] m, input logic t);
        actr     = a;
        p_move   = m;
        target   = t;
        calc_dmg = 1'b1;
        @(negedge clk);
        calc_dmg = 1'b0;
    endtask

    task automatic wait_rv();
        for (int i = 0; i < 8 && result_valid !== 1'b1; i++) @(negedge clk);
        check("wait_rv", result_valid, 1'b1);
    endtask

    task automatic commit();
        app_dmg = 1'b1;
        @(negedge clk);
        app_dmg = 1'b0;
    endtask

    task automatic do_op(input logic a, input logic [1:0] m, input logic t);
        start_calc(a, m, t);
        if (m_busy) begin
            wait_rv();
            commit();
        end else begin
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0; actr = 1'b0; p_move = 2'd0; target = 1'b0;
        calc_dmg = 1'b0; app_dmg = 1'b0;
        do_reset();
        check("rst_p_hp", p_hp, 4'd9);
        check("rst_ai_hp", ai_hp, 4'd9);
        check("rst_busy", busy, 1'b0);
        check("rst_rv", result_valid, 1'b0);

        // AI move from seed 16'hACE1: move 1, roll 8 -> hit, 2 damage to player
        start_calc(1'b1, 2'd3, 1'b0);
        check("lat_busy_e0", busy, 1'b1);
        check("lat_rv_e0", result_valid, 1'b0);
        @(negedge clk);
        check("lat_rv_e1", result_valid, 1'b0);
        @(negedge clk);
        check("lat_rv_e2", result_valid, 1'b1);
        check("ai_move", move_used, 2'd1);
        check("ai_hit", hit, 1'b1);
        check("ai_dmg", dmg_out, 3'd2);
        check("ai_pre_commit_p_hp", p_hp, 4'd9);
        commit();
        check("ai_p_hp", p_hp, 4'd7);
        check("ai_ai_hp", ai_hp, 4'd9);
        check("ai_busy_clr", busy, 1'b0);

        // player move 0 at AI
        do_op(1'b0, 2'd0, 1'b1);
        check("m0_hit", hit, 1'b1);
        check("m0_dmg", dmg_out, 3'd1);
        check("m0_ai_hp", ai_hp, 4'd8);
        check("m0_p_hp", p_hp, 4'd7);

        // stray commit without a pending result
        commit();
        check("stray_app_ai", ai_hp, 4'd8);
        check("stray_app_p", p_hp, 4'd7);

        // calc while busy is dropped; result held until committed
        start_calc(1'b0, 2'd3, 1'b0);
        start_calc(1'b0, 2'd0, 1'b1);
        wait_rv();
        repeat (5) @(negedge clk);
        check("held_rv", result_valid, 1'b1);
        check("held_move", move_used, 2'd3);
        check("held_ai_hp", ai_hp, 4'd8);
        commit();

        // same-edge calc+commit: commit wins, next calc accepted one edge later
        start_calc(1'b0, 2'd1, 1'b1);
        wait_rv();
        app_dmg = 1'b1; calc_dmg = 1'b1;
        @(negedge clk);
        app_dmg = 1'b0; calc_dmg = 1'b0;
        check("same_edge_busy", busy, 1'b0);
        start_calc(1'b0, 2'd2, 1'b0);
        check("next_accept_busy", busy, 1'b1);
        wait_rv();
        commit();

        // AI turns with p_move driven as junk
        for (int i = 0; i < 4; i++) do_op(1'b1, 2'(i), 1'(i % 2));

        // reset while a result is pending
        start_calc(1'b0, 2'd3, 1'b1);
        wait_rv();
        do_reset();
        check("midrst_p_hp", p_hp, 4'd9);
        check("midrst_ai_hp", ai_hp, 4'd9);
        check("midrst_rv", result_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);

        // saturation: move 0 always hits for 1
        for (int i = 1; i <= 10; i++) begin
            do_op(1'b0, 2'd0, 1'b0);
            if (i == 9)  check("sat_p_hp_9", p_hp, 4'd0);
            if (i == 10) check("sat_p_hp_10", p_hp, 4'd0);
        end
        check("sat_ai_hp", ai_hp, 4'd9);

`ifdef PBS_FAINT_LOCK_EN
        start_calc(1'b0, 2'd0, 1'b1);
        check("lock_busy", busy, 1'b0);
        @(negedge clk);
        check("lock_ai_hp", ai_hp, 4'd9);
`else
        start_calc(1'b0, 2'd0, 1'b1);
        check("nolock_busy", busy, 1'b1);
        wait_rv();
        commit();
        check("nolock_ai_hp", ai_hp, 4'd8);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
